// File: rtl/frac_logic_pkg.sv
// Shared types and constants for the fracturable K-input logic element.
// Build option: FRAC_LOGIC_PARITY_EN appends a parity bit to the configuration chain.
package frac_logic_pkg;

   typedef enum logic [1:0] {
      ST_UNCONF     = 2'd0,
      ST_LOADING    = 2'd1,
      ST_CONFIGURED = 2'd2,
      ST_ERROR      = 2'd3
   } cfg_state_t;

`ifdef FRAC_LOGIC_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   // MASK_LSB is absolute; MODE_BIT and PAR_BIT are offsets past the 2**K mask bits
   localparam int MASK_LSB = 0;
   localparam int MODE_BIT = 0;
   localparam int PAR_BIT  = 1;

   function automatic int cfg_len(input int k, input bit parity);
      return (1 << k) + (parity ? 2 : 1);
   endfunction

endpackage

// File: rtl/frac_logic_k_if.sv
// Configuration-chain and LUT signal bundle for frac_logic_k.
// Build option: FRAC_LOGIC_PARITY_EN (cfg_err is only meaningful with it).
interface frac_logic_k_if #(
   parameter int K = 4
);
   logic         ccff_en;
   logic         ccff_head;
   logic [K-1:0] frac_logic_in;
   logic [1:0]   frac_logic_out;
   logic         ccff_tail;
   logic         cfg_valid;
   logic         cfg_err;

   modport master (
      output ccff_en, ccff_head, frac_logic_in,
      input  frac_logic_out, ccff_tail, cfg_valid, cfg_err
   );

   modport slave (
      input  ccff_en, ccff_head, frac_logic_in,
      output frac_logic_out, ccff_tail, cfg_valid, cfg_err
   );
endinterface

// File: rtl/frac_logic_cfg_chain.sv
// Configuration shift chain with load-tracking FSM for frac_logic_k.
// Build option: FRAC_LOGIC_PARITY_EN adds the parity bit, the ERROR state and cfg_err.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_UNCONF     | after reset, nothing shifted in yet
// ST_LOADING    | 1..CFG_LEN-1 bits received, outputs held at 0
// ST_CONFIGURED | exactly CFG_LEN bits received, LUT outputs enabled
// ST_ERROR      | full word received with odd parity (parity build only)
module frac_logic_cfg_chain
   import frac_logic_pkg::*;
#(
   parameter  int K       = 4,
   localparam int CFG_LEN = cfg_len(K, PARITY_EN),
   localparam int CNT_W   = $clog2(CFG_LEN + 1)
) (
   input  logic               prog_clk,
   input  logic               prog_reset_n,
   input  logic               ccff_en,
   input  logic               ccff_head,
   output logic [CFG_LEN-1:0] cfg,
   output logic               cfg_valid,
   output logic               cfg_err
);

   cfg_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [CFG_LEN-1:0] cfg_next;

   assign cnt_inc  = cnt + 1'b1;
   assign cfg_next = {cfg[CFG_LEN-2:0], ccff_head};

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         cfg       <= '0;
         cnt       <= '0;
         state     <= ST_UNCONF;
         cfg_valid <= 1'b0;
`ifdef FRAC_LOGIC_PARITY_EN
         cfg_err   <= 1'b0;
`endif
      end else if (ccff_en) begin
         cfg <= cfg_next;
         case (state)
            ST_LOADING: begin
               cnt <= cnt_inc;
               if (cnt_inc == CNT_W'(CFG_LEN)) begin
`ifdef FRAC_LOGIC_PARITY_EN
                  // parity is judged on the word as it stands after this edge
                  if (^cfg_next) begin
                     state   <= ST_ERROR;
                     cfg_err <= 1'b1;
                  end else begin
                     state     <= ST_CONFIGURED;
                     cfg_valid <= 1'b1;
                  end
`else
                  state     <= ST_CONFIGURED;
                  cfg_valid <= 1'b1;
`endif
               end
            end
            default: begin
               // first bit of a fresh load; any previous word is invalidated here
               state     <= ST_LOADING;
               cnt       <= CNT_W'(1);
               cfg_valid <= 1'b0;
`ifdef FRAC_LOGIC_PARITY_EN
               cfg_err   <= 1'b0;
`endif
            end
         endcase
      end
   end

`ifndef FRAC_LOGIC_PARITY_EN
   assign cfg_err = 1'b0;
`endif

endmodule

// File: rtl/frac_logic_k.sv
// Fracturable K-input LUT: one LUT-K or two LUT-(K-1) sharing inputs, gated by cfg_valid.
// Build option: FRAC_LOGIC_PARITY_EN enables configuration parity checking.
module frac_logic_k
   import frac_logic_pkg::*;
#(
   parameter int K = 4
) (
   input  logic           prog_clk,
   input  logic           prog_reset_n,
   frac_logic_k_if.slave  bus
);

   localparam int CFG_LEN = cfg_len(K, PARITY_EN);
   localparam int HALF    = 1 << (K - 1);

   logic [CFG_LEN-1:0] cfg;
   logic               cfg_valid;
   logic               cfg_err;
   logic [HALF-1:0]    mask_lo;
   logic [HALF-1:0]    mask_hi;
   logic               mode;
   logic               lo;
   logic               hi;
   logic               lutk;

   frac_logic_cfg_chain #(.K(K)) u_chain (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .ccff_en      (bus.ccff_en),
      .ccff_head    (bus.ccff_head),
      .cfg          (cfg),
      .cfg_valid    (cfg_valid),
      .cfg_err      (cfg_err)
   );

   assign mask_lo = cfg[MASK_LSB        +: HALF];
   assign mask_hi = cfg[MASK_LSB + HALF +: HALF];
   assign mode    = cfg[(1 << K) + MODE_BIT];

   assign lo   = mask_lo[bus.frac_logic_in[K-2:0]];
   assign hi   = mask_hi[bus.frac_logic_in[K-2:0]];
   assign lutk = bus.frac_logic_in[K-1] ? hi : lo;

   assign bus.frac_logic_out[0] = (mode ? lo : lutk) & cfg_valid;
   assign bus.frac_logic_out[1] = hi & cfg_valid;
   assign bus.ccff_tail         = cfg[CFG_LEN-1];
   assign bus.cfg_valid         = cfg_valid;
   assign bus.cfg_err           = cfg_err;

endmodule

// File: tb/tb_frac_logic_k.sv
// Directed self-checking bench for frac_logic_k with K=4 (either parity build).
module tb_frac_logic_k;

   localparam int K = 4;
`ifdef FRAC_LOGIC_PARITY_EN
   localparam int CFG_LEN = 18;
`else
   localparam int CFG_LEN = 17;
`endif

   typedef struct {
      logic        mode;
      logic [15:0] mask;
      logic [3:0]  in;
      logic [1:0]  exp_out;
   } vec_t;

   logic prog_clk = 1'b0;
   logic prog_reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [CFG_LEN-1:0] mdl = '0;
   vec_t vecs[9];

   frac_logic_k_if #(.K(K)) bus ();

   frac_logic_k #(.K(K)) dut (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .bus          (bus)
   );

   always #5 prog_clk = ~prog_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [CFG_LEN-1:0] make_word(input logic mode, input logic [15:0] mask,
                                                    input logic bad_par);
      logic [CFG_LEN-1:0] w;
`ifdef FRAC_LOGIC_PARITY_EN
      w = {(^{mode, mask}) ^ bad_par, mode, mask};
`else
      w = {mode, mask};
      if (bad_par) w = w;
`endif
      return w;
   endfunction

   task automatic shift_bit(input logic b);
      bus.ccff_en   = 1'b1;
      bus.ccff_head = b;
      @(posedge prog_clk);
      #1;
      bus.ccff_en = 1'b0;
      mdl = {mdl[CFG_LEN-2:0], b};
      check("tail", 32'(bus.ccff_tail), 32'(mdl[CFG_LEN-1]));
   endtask

   // first bit shifted lands at the highest chain position
   task automatic shift_range(input logic [CFG_LEN-1:0] w, input int first, input int last);
      for (int i = first; i <= last; i++) shift_bit(w[CFG_LEN-1-i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge prog_clk);
      #1;
   endtask

   initial begin
      logic [CFG_LEN-1:0] w;
      logic               exp_tail;

      vecs[0] = '{1'b0, 16'h8000, 4'hF, 2'b11};
      vecs[1] = '{1'b0, 16'h8000, 4'hE, 2'b00};
      vecs[2] = '{1'b0, 16'h8000, 4'h7, 2'b10};
      vecs[3] = '{1'b1, 16'hE896, 4'b0111, 2'b11};
      vecs[4] = '{1'b1, 16'hE896, 4'b0000, 2'b00};
      vecs[5] = '{1'b1, 16'hE896, 4'b0001, 2'b01};
      vecs[6] = '{1'b1, 16'hE896, 4'b1101, 2'b10};
      vecs[7] = '{1'b0, 16'hE896, 4'b1110, 2'b11};
      vecs[8] = '{1'b0, 16'hE896, 4'b0011, 2'b10};

      bus.ccff_en       = 1'b0;
      bus.ccff_head     = 1'b0;
      bus.frac_logic_in = 4'hF;

      // reset state
      #12;
      check("rst_out",   32'(bus.frac_logic_out), 32'd0);
      check("rst_valid", 32'(bus.cfg_valid), 32'd0);
      check("rst_tail",  32'(bus.ccff_tail), 32'd0);
      check("rst_err",   32'(bus.cfg_err), 32'd0);
      @(negedge prog_clk);
      prog_reset_n = 1'b1;
      idle(2);

      // table: load each vector, then evaluate the LUT
      for (int v = 0; v < 9; v++) begin
         w = make_word(vecs[v].mode, vecs[v].mask, 1'b0);
         shift_range(w, 0, CFG_LEN-2);
         check("pre_valid", 32'(bus.cfg_valid), 32'd0);
         shift_range(w, CFG_LEN-1, CFG_LEN-1);
         check("vec_valid", 32'(bus.cfg_valid), 32'd1);
         check("vec_err",   32'(bus.cfg_err), 32'd0);
         bus.frac_logic_in = vecs[v].in;
         #1;
         check($sformatf("vec%0d_out", v), 32'(bus.frac_logic_out), 32'(vecs[v].exp_out));
      end

      // idle cycles keep the configuration
      idle(3);
      check("hold_valid", 32'(bus.cfg_valid), 32'd1);

      // incomplete load then gap
      prog_reset_n = 1'b0;
      mdl = '0;
      #2;
      prog_reset_n = 1'b1;
      idle(1);
      w = make_word(1'b0, 16'hFFFF, 1'b0);
      shift_range(w, 0, CFG_LEN-2);
      check("part_valid", 32'(bus.cfg_valid), 32'd0);
      for (int i = 0; i < 16; i++) begin
         bus.frac_logic_in = 4'(i);
         #1;
         check("part_out", 32'(bus.frac_logic_out), 32'd0);
      end
      idle(5);
      check("gap_valid", 32'(bus.cfg_valid), 32'd0);
      shift_range(w, CFG_LEN-1, CFG_LEN-1);
      check("gap_done_valid", 32'(bus.cfg_valid), 32'd1);
      bus.frac_logic_in = 4'hF;
      #1;
      check("gap_done_out", 32'(bus.frac_logic_out), 32'd3);

      // re-shift while configured
      exp_tail = mdl[CFG_LEN-2];
      shift_bit(1'b1);
      check("reshift_valid", 32'(bus.cfg_valid), 32'd0);
      check("reshift_out",   32'(bus.frac_logic_out), 32'd0);
      check("reshift_cnt",   32'(dut.u_chain.cnt), 32'd1);
      check("reshift_tail",  32'(bus.ccff_tail), 32'(exp_tail));
      shift_bit(1'b1);
      shift_bit(1'b0);
      check("reload_cnt", 32'(dut.u_chain.cnt), 32'd3);

      // async reset mid-reload, sampled before any further edge
      #2;
      prog_reset_n = 1'b0;
      mdl = '0;
      #1;
      check("arst_cfg",   32'(dut.u_chain.cfg), 32'd0);
      check("arst_cnt",   32'(dut.u_chain.cnt), 32'd0);
      check("arst_valid", 32'(bus.cfg_valid), 32'd0);
      check("arst_tail",  32'(bus.ccff_tail), 32'd0);
      check("arst_out",   32'(bus.frac_logic_out), 32'd0);
      @(negedge prog_clk);
      prog_reset_n = 1'b1;
      idle(1);

`ifdef FRAC_LOGIC_PARITY_EN
      // bad parity -> ERROR, then corrected reload
      w = make_word(1'b0, 16'h8000, 1'b1);
      shift_range(w, 0, CFG_LEN-1);
      bus.frac_logic_in = 4'hF;
      #1;
      check("par_err",   32'(bus.cfg_err), 32'd1);
      check("par_valid", 32'(bus.cfg_valid), 32'd0);
      check("par_out",   32'(bus.frac_logic_out), 32'd0);
      w = make_word(1'b0, 16'h8000, 1'b0);
      shift_bit(w[CFG_LEN-1]);
      check("par_clear_err", 32'(bus.cfg_err), 32'd0);
      shift_range(w, 1, CFG_LEN-1);
      #1;
      check("par_ok_valid", 32'(bus.cfg_valid), 32'd1);
      check("par_ok_err",   32'(bus.cfg_err), 32'd0);
      check("par_ok_out",   32'(bus.frac_logic_out), 32'd3);
`else
      w = make_word(1'b0, 16'h8000, 1'b0);
      shift_range(w, 0, CFG_LEN-1);
      check("noparity_err", 32'(bus.cfg_err), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
